// File: rtl/quad_decoder_pkg.sv
// Shared register map, bit positions and response code for the quadrature decoder.
package quad_decoder_pkg;

  // Word index of each register (byte offset = index * 4)
  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_PRESET  = 3'd1,
    REG_COMPARE = 3'd2,
    REG_SCRATCH = 3'd3,
    REG_COUNT   = 3'd4,
    REG_STATUS  = 3'd5
  } reg_idx_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_LOAD   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_ERR = 0;
  localparam int STAT_CMP = 1;
  localparam int STAT_DIR = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Merge write data into a register, one byte per strobe bit
  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_axil_regs_if.sv
// AXI4-Lite slave bundle for the quadrature decoder register block.
interface quad_decoder_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/quad_decoder_core.sv
// Encoder front end: phase synchronizer, x4 decode, position counter,
// preset load and compare/error sticky flags.
module quad_decoder_core
  import quad_decoder_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enable,
  input  logic        invert,
  input  logic        load,
  input  logic [31:0] preset,
  input  logic [31:0] compare,
  input  logic        clr_err,
  input  logic        clr_cmp,
  output logic [31:0] count,
  output logic        err_flag,
  output logic        cmp_flag,
  output logic        dir_dn
);

  logic [1:0]  ph_meta, ph_sync, ph_prev;
  logic        step_fwd, step_rev, step_bad, step, step_dn, upd;
  logic [31:0] count_nxt;

  // Two-flop synchronizer on {A,B} plus one older sample for transition decode
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      ph_meta <= 2'b00;
      ph_sync <= 2'b00;
      ph_prev <= 2'b00;
    end else begin
      ph_meta <= {enc_a, enc_b};
      ph_sync <= ph_meta;
      ph_prev <= ph_sync;
    end
  end

  // x4 decode; forward order is 00->01->11->10->00, load overrides any step
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    case ({ph_prev, ph_sync})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_rev = 1'b1;
      default: ;
    endcase
    step_bad = ((ph_prev ^ ph_sync) == 2'b11);
    step     = enable & (step_fwd | step_rev) & ~load;
    step_dn  = step_rev ^ invert;
    upd      = load | step;
    if (load)        count_nxt = preset;
    else if (step)   count_nxt = step_dn ? count - 32'd1 : count + 32'd1;
    else             count_nxt = count;
  end

  // Position, last direction and sticky flags; a set event beats a same-cycle clear
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count    <= 32'd0;
      err_flag <= 1'b0;
      cmp_flag <= 1'b0;
      dir_dn   <= 1'b0;
    end else begin
      count    <= count_nxt;
      if (step) dir_dn <= step_dn;
      err_flag <= step_bad | (err_flag & ~clr_err);
      cmp_flag <= (upd && (count_nxt == compare)) | (cmp_flag & ~clr_cmp);
    end
  end

endmodule

// File: rtl/quad_decoder_axil_regs.sv
// AXI4-Lite register block around the quadrature decoder core.
// One outstanding write; AW and W are captured independently and committed together.
module quad_decoder_axil_regs
  import quad_decoder_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  quad_decoder_axil_regs_if.slave  s_axi,
  input  logic                     ENC_A,
  input  logic                     ENC_B,
  output logic                     COMPARE_IRQ
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  logic            bus_up, aw_held, w_held, bvalid_q, rvalid_q;
  logic [AW-3:0]   aw_idx, ar_idx;
  logic [DW-1:0]   w_data, rdata_q, rd_mux;
  logic [DW/8-1:0] w_strb;
  logic [DW-1:0]   ctrl_q, preset_q, compare_q, scratch_q;
  logic [31:0]     count;
  logic            err_flag, cmp_flag, dir_dn;
  logic            aw_hs, w_hs, ar_hs, wr_commit, load, clr_err, clr_cmp;
  logic            unused_bits;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign s_axi.S_AXI_AWREADY = bus_up & ~aw_held & ~bvalid_q;
  assign s_axi.S_AXI_WREADY  = bus_up & ~w_held & ~bvalid_q;
  assign s_axi.S_AXI_ARREADY = bus_up & ~rvalid_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign aw_hs     = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_hs      = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
  assign ar_hs     = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  assign ar_idx    = s_axi.S_AXI_ARADDR[AW-1:2];
  assign wr_commit = aw_held & w_held;
  assign load      = wr_commit && (aw_idx == REG_CTRL) && w_strb[0] && w_data[CTRL_LOAD];
  assign clr_err   = wr_commit && (aw_idx == REG_STATUS) && w_strb[0] && w_data[STAT_ERR];
  assign clr_cmp   = wr_commit && (aw_idx == REG_STATUS) && w_strb[0] && w_data[STAT_CMP];

  // Write channel: hold AW and W separately, commit when both present, then respond
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bus_up   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      bus_up <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi.S_AXI_AWADDR[AW-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi.S_AXI_WDATA;
        w_strb <= s_axi.S_AXI_WSTRB;
      end
      if (wr_commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register file; COUNT/STATUS live in the core, unmapped offsets ignore writes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q    <= '0;
      preset_q  <= '0;
      compare_q <= '0;
      scratch_q <= '0;
    end else if (wr_commit) begin
      case (aw_idx)
        REG_CTRL:    ctrl_q    <= apply_strb(ctrl_q, w_data, w_strb);
        REG_PRESET:  preset_q  <= apply_strb(preset_q, w_data, w_strb);
        REG_COMPARE: compare_q <= apply_strb(compare_q, w_data, w_strb);
        REG_SCRATCH: scratch_q <= apply_strb(scratch_q, w_data, w_strb);
        default: ;
      endcase
    end
  end

  // Read mux; sampled from current register values, so a same-cycle write is not visible
  always_comb begin
    rd_mux = '0;
    case (ar_idx)
      REG_CTRL:    rd_mux = ctrl_q;
      REG_PRESET:  rd_mux = preset_q;
      REG_COMPARE: rd_mux = compare_q;
      REG_SCRATCH: rd_mux = scratch_q;
      REG_COUNT:   rd_mux = count;
      REG_STATUS: begin
        rd_mux[STAT_ERR] = err_flag;
        rd_mux[STAT_CMP] = cmp_flag;
        rd_mux[STAT_DIR] = dir_dn;
      end
      default: ;
    endcase
  end

  // Read channel: register data on AR handshake, hold until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  // Level interrupt from the compare sticky flag
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) COMPARE_IRQ <= 1'b0;
    else          COMPARE_IRQ <= cmp_flag & ctrl_q[CTRL_IRQ_EN];
  end

  quad_decoder_core u_core (
    .clk_sys  (ACLK),
    .rst_b    (ARESETN),
    .enc_a    (ENC_A),
    .enc_b    (ENC_B),
    .enable   (ctrl_q[CTRL_EN]),
    .invert   (ctrl_q[CTRL_INV]),
    .load     (load),
    .preset   (preset_q),
    .compare  (compare_q),
    .clr_err  (clr_err),
    .clr_cmp  (clr_cmp),
    .count    (count),
    .err_flag (err_flag),
    .cmp_flag (cmp_flag),
    .dir_dn   (dir_dn)
  );

endmodule

// File: tb/tb_quad_decoder_axil_regs.sv
// Scoreboard bench: tasks push expected responses, a negedge monitor pops and compares.
module tb_quad_decoder_axil_regs;
  import quad_decoder_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic ENC_A = 1'b0;
  logic ENC_B = 1'b0;
  logic COMPARE_IRQ;
  logic [1:0] enc_ph = 2'b00;

  quad_decoder_axil_regs_if bus ();

  quad_decoder_axil_regs dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .s_axi       (bus),
    .ENC_A       (ENC_A),
    .ENC_B       (ENC_B),
    .COMPARE_IRQ (COMPARE_IRQ)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    string       name;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t rq[$];
  string   wq[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expectation
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_r: got RVALID with no read outstanding");
        end else begin
          rd_exp_t e;
          e = rq.pop_front();
          check(e.name, bus.S_AXI_RDATA, e.data);
          check({e.name, "_rresp"}, {30'd0, bus.S_AXI_RRESP}, {30'd0, RESP_OKAY});
        end
      end
      if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
        if (wq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_b: got BVALID with no write outstanding");
        end else begin
          string n;
          n = wq.pop_front();
          check(n, {30'd0, bus.S_AXI_BRESP}, {30'd0, RESP_OKAY});
        end
      end
    end
  end

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_dly, input bit wait_b, input string name);
    bit aw_done, w_done, aw_fire, w_fire;
    aw_done = 0; w_done = 0;
    wq.push_back({name, "_bresp"});
    @(negedge ACLK);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    for (int i = 0; i < 100; i++) begin
      if (i >= w_dly && !w_done) bus.S_AXI_WVALID = 1'b1;
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge ACLK);
      if (aw_fire) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_fire)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1; end
      if (aw_done && w_done) break;
    end
    if (!(aw_done && w_done)) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no AW/W handshake expected handshake", name);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      wq.delete();
    end
    if (wait_b) begin
      for (int i = 0; i < 100 && wq.size() != 0; i++) @(negedge ACLK);
      if (wq.size() != 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s_b_timeout: got no B response expected one", name);
        wq.delete();
      end
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
    bit done, fire;
    rd_exp_t e;
    done = 0;
    e.name = name;
    e.data = exp;
    rq.push_back(e);
    @(negedge ACLK);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      fire = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(negedge ACLK);
      if (fire) begin bus.S_AXI_ARVALID = 1'b0; done = 1; end
    end
    if (!done) bus.S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 100 && rq.size() != 0; i++) @(negedge ACLK);
    if (rq.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no R response expected one", name);
      rq.delete();
    end
  endtask

  task automatic enc_to(input logic [1:0] ph);
    @(negedge ACLK);
    enc_ph = ph;
    {ENC_A, ENC_B} = ph;
    repeat (6) @(negedge ACLK);
  endtask

  function automatic logic [1:0] fwd_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic enc_fwd(input int n);
    for (int i = 0; i < n; i++) enc_to(fwd_of(enc_ph));
  endtask

  task automatic enc_rev(input int n);
    for (int i = 0; i < n; i++) enc_to(rev_of(enc_ph));
  endtask

  localparam logic [4:0] A_CTRL    = 5'h00;
  localparam logic [4:0] A_PRESET  = 5'h04;
  localparam logic [4:0] A_COMPARE = 5'h08;
  localparam logic [4:0] A_SCRATCH = 5'h0C;
  localparam logic [4:0] A_COUNT   = 5'h10;
  localparam logic [4:0] A_STATUS  = 5'h14;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    check("rst_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    check("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, bus.S_AXI_RVALID},  32'd0);
    check("rst_irq",     {31'd0, COMPARE_IRQ},       32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("rel_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    check("rel_wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
    check("rel_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
    axi_read(A_COUNT,  32'd0, "rst_count");
    axi_read(A_STATUS, 32'd0, "rst_status");

    // Basic RW map
    axi_write(A_CTRL,    32'd1, 4'hF, 0, 1, "wr_ctrl");
    axi_write(A_PRESET,  32'd2, 4'hF, 0, 1, "wr_preset");
    axi_write(A_COMPARE, 32'd3, 4'hF, 0, 1, "wr_compare");
    axi_write(A_SCRATCH, 32'd4, 4'hF, 0, 1, "wr_scratch");
    axi_read(A_CTRL,    32'd1, "rd_ctrl");
    axi_read(A_PRESET,  32'd2, "rd_preset");
    axi_read(A_COMPARE, 32'd3, "rd_compare");
    axi_read(A_SCRATCH, 32'd4, "rd_scratch");
    axi_write(5'h1C, 32'hDEADBEEF, 4'hF, 0, 1, "wr_unmapped");
    axi_read(5'h18, 32'd0, "rd_unmapped18");
    axi_read(5'h1C, 32'd0, "rd_unmapped1c");

    // Byte strobes
    axi_write(A_SCRATCH, 32'hFFFFFFFF, 4'hF, 0, 1, "wr_scr_ones");
    axi_write(A_SCRATCH, 32'h12345678, 4'b0101, 0, 1, "wr_scr_strb");
    axi_read(A_SCRATCH, 32'hFF34FF78, "rd_scr_strb");

    // Counting: forward, reverse, inverted; compare=3 is crossed on the way to 8
    enc_fwd(8);
    axi_read(A_COUNT,  32'd8, "count_fwd8");
    axi_read(A_STATUS, 32'h2, "status_cmp_up");
    enc_rev(3);
    axi_read(A_COUNT,  32'd5, "count_rev3");
    axi_read(A_STATUS, 32'h6, "status_cmp_dn");
    axi_write(A_CTRL, 32'd3, 4'hF, 0, 1, "wr_ctrl_inv");
    enc_fwd(2);
    axi_read(A_COUNT, 32'd3, "count_inv2");
    check("irq_disabled", {31'd0, COMPARE_IRQ}, 32'd0);
    axi_write(A_CTRL, 32'd0, 4'hF, 0, 1, "wr_ctrl_off");
    enc_fwd(1);
    axi_read(A_COUNT, 32'd3, "count_disabled");
    axi_write(A_STATUS, 32'h3, 4'hF, 0, 1, "wr_status_clr");
    axi_read(A_STATUS, 32'h4, "status_cleared");

    // Preset load, wrap to zero, compare hit, IRQ, wrap below zero
    axi_write(A_COMPARE, 32'd0, 4'hF, 0, 1, "wr_cmp0");
    axi_write(A_PRESET, 32'hFFFFFFFE, 4'hF, 0, 1, "wr_preset_wrap");
    axi_write(A_CTRL, 32'h5, 4'hF, 0, 1, "wr_ctrl_load");
    axi_read(A_COUNT, 32'hFFFFFFFE, "count_loaded");
    axi_read(A_CTRL, 32'h5, "ctrl_load_readback");
    enc_fwd(2);
    axi_read(A_COUNT, 32'd0, "count_wrap_up");
    axi_read(A_STATUS, 32'h2, "status_cmp_wrap");
    axi_write(A_CTRL, 32'h9, 4'hF, 0, 1, "wr_ctrl_irq");
    repeat (2) @(negedge ACLK);
    check("irq_enabled", {31'd0, COMPARE_IRQ}, 32'd1);
    enc_rev(1);
    axi_read(A_COUNT, 32'hFFFFFFFF, "count_wrap_dn");
    axi_write(A_STATUS, 32'h2, 4'h0, 0, 1, "wr_status_nostrb");
    axi_read(A_STATUS, 32'h6, "status_nostrb");
    axi_write(A_STATUS, 32'h2, 4'h1, 0, 1, "wr_status_cmpclr");
    axi_read(A_STATUS, 32'h4, "status_cmpclr");
    repeat (2) @(negedge ACLK);
    check("irq_cleared", {31'd0, COMPARE_IRQ}, 32'd0);

    // Illegal double-phase step
    enc_rev(1);
    axi_read(A_COUNT, 32'hFFFFFFFE, "count_pre_err");
    enc_to(2'b11);
    axi_read(A_COUNT, 32'hFFFFFFFE, "count_err_hold");
    axi_read(A_STATUS, 32'h5, "status_err");
    axi_write(A_STATUS, 32'h1, 4'hF, 0, 1, "wr_status_errclr");
    axi_read(A_STATUS, 32'h4, "status_errclr");
    axi_write(A_CTRL, 32'd0, 4'hF, 0, 1, "wr_ctrl_off2");
    enc_fwd(2);

    // Back-pressured write response
    @(posedge ACLK); #1 bus.S_AXI_BREADY = 1'b0;
    axi_write(A_SCRATCH, 32'hA5A5A5A5, 4'hF, 0, 0, "wr_bp");
    repeat (10) @(negedge ACLK);
    check("bp_bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd1);
    check("bp_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    check("bp_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    @(posedge ACLK); #1 bus.S_AXI_BREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    check("bp_released", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    axi_read(A_SCRATCH, 32'hA5A5A5A5, "rd_bp");

    // Address leads data by 5 cycles: one commit, one response
    axi_write(A_PRESET, 32'h11, 4'hF, 5, 1, "wr_aw_first");
    axi_read(A_PRESET, 32'h11, "rd_aw_first");

    // Reset while write data is held: no response afterwards
    @(negedge ACLK);
    bus.S_AXI_WDATA  = 32'h77;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    bus.S_AXI_WVALID = 1'b0;
    check("held_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
    ARESETN = 1'b0;
    #1;
    check("arst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (10) @(negedge ACLK);
    check("post_rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    check("post_rst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd1);
    axi_read(A_PRESET, 32'd0, "rd_post_rst");

    repeat (5) @(negedge ACLK);
    check("rq_empty", rq.size(), 32'd0);
    check("wq_empty", wq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
